// File: rtl/apb_spi_ctrl.sv
// APB3 register front-end for the SPI master: holds one TX and one RX word,
// launches transfers through a three-state FSM and reports status and interrupt.
module apb_spi_ctrl #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_WIDTH-1:0]  paddr,
  input  logic [31:0]            pwdata,
  output logic [31:0]            prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic                   spi_start,
  output logic [WORD_LENGTH-1:0] spi_wdata,
  input  logic                   spi_ready,
  input  logic [WORD_LENGTH-1:0] spi_rdata,
  input  logic                   spi_rx_valid,
  output logic                   irq,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic                   ctrl_en, ctrl_irq_en;
  logic                   tx_full, rx_valid, overrun;
  logic [WORD_LENGTH-1:0] tx_hold, rx_hold;

  logic       access, wr_ctrl, wr_status, wr_tx, wr_rx, rd_rx;
  logic       tx_wr_err, tx_accept, capture, overrun_set, busy;
  logic [1:0] reg_sel;
  logic       unused_bits;

  assign reg_sel   = paddr[3:2];
  assign access    = psel & penable;
  assign wr_ctrl   = access & pwrite & (reg_sel == 2'd0);
  assign wr_status = access & pwrite & (reg_sel == 2'd1);
  assign wr_tx     = access & pwrite & (reg_sel == 2'd2);
  assign wr_rx     = access & pwrite & (reg_sel == 2'd3);
  assign rd_rx     = access & ~pwrite & (reg_sel == 2'd3);

  // The START cycle frees the TX slot at its closing edge, so a write landing
  // on that same edge is accepted and refills the slot.
  assign tx_wr_err   = wr_tx & tx_full & (state != S_START);
  assign tx_accept   = wr_tx & ~tx_wr_err;
  assign capture     = (state == S_WAIT_DONE) & spi_rx_valid;
  assign overrun_set = capture & rx_valid & ~rd_rx;
  assign busy        = (state != S_IDLE);

  assign pready      = 1'b1;
  assign pslverr     = tx_wr_err | wr_rx;
  assign dbg_state   = state;
  assign unused_bits = ^{paddr, pwdata};

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (reg_sel)
        2'd0: prdata[1:0] = {ctrl_irq_en, ctrl_en};
        2'd1: prdata[3:0] = {overrun, busy, rx_valid, tx_full};
        2'd3: prdata[WORD_LENGTH-1:0] = rx_hold;
        default: prdata = '0;
      endcase
    end
  end

  // Master handshake: spi_ready=1 means the master can accept a word; spi_start
  // is a one-cycle launch with spi_wdata valid from then until spi_rx_valid,
  // which qualifies spi_rdata for exactly the cycle it is high.
  always_comb begin
    state_nxt = state;
    spi_start = 1'b0;
    case (state)
      S_IDLE:      if (ctrl_en && tx_full && spi_ready) state_nxt = S_START;
      S_START: begin
        spi_start = 1'b1;
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: if (spi_rx_valid) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      tx_full     <= 1'b0;
      rx_valid    <= 1'b0;
      overrun     <= 1'b0;
      tx_hold     <= '0;
      rx_hold     <= '0;
      spi_wdata   <= '0;
      irq         <= 1'b0;
    end else begin
      state <= state_nxt;
      irq   <= ctrl_irq_en & rx_valid;

      if (wr_ctrl) begin
        ctrl_en     <= pwdata[0];
        ctrl_irq_en <= pwdata[1];
      end

      if (state == S_IDLE && state_nxt == S_START) spi_wdata <= tx_hold;

      if (tx_accept) begin
        tx_hold <= pwdata[WORD_LENGTH-1:0];
        tx_full <= 1'b1;
      end else if (state == S_START) begin
        tx_full <= 1'b0;
      end

      if (capture) begin
        rx_hold  <= spi_rdata;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end

      if (overrun_set)                overrun <= 1'b1;
      else if (wr_status && pwdata[3]) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Bench for apb_spi_ctrl: APB driver tasks, a behavioural SPI master model and
// a scoreboard of expected TX words checked at every spi_start pulse.
module tb_apb_spi_ctrl;

  localparam int W = 8;

  logic          clk, rst_n;
  logic          psel, penable, pwrite;
  logic [3:0]    paddr;
  logic [31:0]   pwdata, prdata;
  logic          pready, pslverr;
  logic          spi_start, spi_ready, spi_rx_valid, irq;
  logic [W-1:0]  spi_wdata, spi_rdata;
  logic [1:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  resp_word;
  int            resp_delay;
  int            start_cnt;
  int            n_checks, n_fail;

  apb_spi_ctrl #(.WORD_LENGTH(W), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .spi_start(spi_start), .spi_wdata(spi_wdata),
    .spi_ready(spi_ready), .spi_rdata(spi_rdata), .spi_rx_valid(spi_rx_valid),
    .irq(irq), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each returns just after its access edge so calls chain back-to-back
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1 data = prdata;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master model: goes busy on spi_start and returns resp_word later
  initial begin
    spi_ready = 1'b1; spi_rx_valid = 1'b0; spi_rdata = '0;
    forever begin
      @(negedge clk);
      if (spi_start) begin
        spi_ready = 1'b0;
        repeat (resp_delay) @(negedge clk);
        spi_rdata = resp_word; spi_rx_valid = 1'b1;
        @(negedge clk);
        spi_rx_valid = 1'b0; spi_ready = 1'b1;
      end
    end
  end

  // scoreboard: every start pulse must carry the next expected TX word
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && spi_start) begin
        start_cnt++;
        if (exp_q.size() == 0) check("start_unexpected", 32'd1, 32'd0);
        else check("spi_wdata_at_start", {24'd0, spi_wdata}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  logic [31:0] rd;
  logic        err;
  int          saved;

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    n_checks = 0; n_fail = 0; start_cnt = 0;
    resp_word = 8'h00; resp_delay = 20;
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;

    // reset values
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_spi_start", {31'd0, spi_start}, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd1);
    apb_read(4'h0, rd); check("rst_ctrl", rd, 32'h0);
    apb_read(4'h4, rd); check("rst_status", rd, 32'h0);
    apb_read(4'h8, rd); check("rst_txdata", rd, 32'h0);
    apb_read(4'hC, rd); check("rst_rxdata", rd, 32'h0);

    // basic transfer with interrupt
    apb_write(4'h0, 32'h3, err);
    resp_word = 8'h3C; exp_q.push_back(8'hA5);
    apb_write(4'h8, 32'hA5, err); check("tx_wr_err", {31'd0, err}, 32'd0);
    wait_cycles(30);
    check("one_start", start_cnt, 1);
    apb_read(4'h4, rd); check("status_rx_valid", rd, 32'h2);
    check("irq_set", {31'd0, irq}, 32'd1);
    apb_read(4'hC, rd); check("rxdata", rd, 32'h3C);
    apb_read(4'h4, rd); check("status_after_rd", rd, 32'h0);
    check("irq_clear", {31'd0, irq}, 32'd0);

    // EN=0: TX slot fills, second write errors, nothing starts
    apb_write(4'h0, 32'h0, err);
    apb_write(4'h8, 32'h11, err); check("tx1_err", {31'd0, err}, 32'd0);
    apb_write(4'h8, 32'h22, err); check("tx2_err", {31'd0, err}, 32'd1);
    apb_read(4'h4, rd); check("status_tx_full", rd, 32'h1);
    saved = start_cnt;
    wait_cycles(5);
    check("no_start_en0", start_cnt, saved);
    apb_write(4'hC, 32'h5, err); check("rxdata_wr_err", {31'd0, err}, 32'd1);
    resp_word = 8'h99; exp_q.push_back(8'h11);
    apb_write(4'h0, 32'h1, err);
    wait_cycles(30);
    check("start_after_en", start_cnt, saved + 1);
    apb_read(4'hC, rd); check("rxdata_en", rd, 32'h99);

    // two transfers without reading: overrun
    resp_word = 8'h81; exp_q.push_back(8'h01);
    apb_write(4'h8, 32'h01, err);
    wait_cycles(30);
    resp_word = 8'h82; exp_q.push_back(8'h02);
    apb_write(4'h8, 32'h02, err);
    wait_cycles(30);
    apb_read(4'h4, rd); check("status_overrun", rd, 32'hA);
    apb_read(4'hC, rd); check("rxdata_overrun", rd, 32'h82);
    apb_read(4'h4, rd); check("status_ovr_only", rd, 32'h8);
    apb_write(4'h4, 32'h8, err); check("status_wr_err", {31'd0, err}, 32'd0);
    apb_read(4'h4, rd); check("status_ovr_clr", rd, 32'h0);

    // spi_ready low holds off the start until it rises
    spi_ready = 1'b0;
    resp_word = 8'h44; exp_q.push_back(8'h33);
    apb_write(4'h8, 32'h33, err);
    saved = start_cnt;
    wait_cycles(10);
    check("no_start_not_ready", start_cnt, saved);
    check("idle_not_ready", {30'd0, dbg_state}, 32'd0);
    spi_ready = 1'b1;
    @(negedge clk); #1;
    check("start_after_ready", {31'd0, spi_start}, 32'd1);
    wait_cycles(30);
    apb_read(4'hC, rd); check("rxdata_ready", rd, 32'h44);

    // TXDATA write landing on the START cycle is accepted
    resp_word = 8'h20; resp_delay = 10;
    exp_q.push_back(8'h77); exp_q.push_back(8'h78);
    apb_write(4'h8, 32'h77, err);
    apb_write(4'h8, 32'h78, err); check("tx_wr_in_start_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    check("wdata_held", {24'd0, spi_wdata}, 32'h77);
    apb_read(4'h4, rd); check("status_busy_full", rd, 32'h5);
    wait_cycles(40);
    apb_read(4'hC, rd); check("rxdata_b2b", rd, 32'h20);
    apb_write(4'h4, 32'h8, err);
    apb_read(4'h4, rd); check("status_b2b_clr", rd, 32'h0);

    // asynchronous reset during WAIT_DONE
    resp_word = 8'h66; resp_delay = 20;
    apb_write(4'h0, 32'h3, err);
    exp_q.push_back(8'h55);
    apb_write(4'h8, 32'h55, err);
    wait_cycles(5);
    check("wait_done_state", {30'd0, dbg_state}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", {30'd0, dbg_state}, 32'd0);
    check("arst_wdata", {24'd0, spi_wdata}, 32'h0);
    check("arst_start", {31'd0, spi_start}, 32'd0);
    check("arst_pslverr", {31'd0, pslverr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(30);
    apb_read(4'h4, rd); check("status_post_rst", rd, 32'h0);
    apb_read(4'h0, rd); check("ctrl_post_rst", rd, 32'h0);
    apb_read(4'hC, rd); check("rxdata_post_rst", rd, 32'h0);
    check("irq_post_rst", {31'd0, irq}, 32'd0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
